// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS arithmetic units: multiplier state encoding
// and the default operand width.
package mips_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/cla_level2_32bit.sv
// Two-level carry-lookahead adder: 4-bit groups with group generate/propagate
// feeding a lookahead carry chain across groups.
module cla_level2_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int GROUPS = WIDTH / 4;

  // Local variables keep the carry chain free of combinational self-loops.
  function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             c_in);
    logic [WIDTH-1:0] g, p, s;
    logic [GROUPS:0]  gc;
    logic             gg, gp, c;
    g     = x & y;
    p     = x ^ y;
    s     = '0;
    gc    = '0;
    gc[0] = c_in;
    for (int gi = 0; gi < GROUPS; gi++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int k = 0; k < 4; k++) begin
        gg = g[4*gi+k] | (p[4*gi+k] & gg);
        gp = gp & p[4*gi+k];
      end
      gc[gi+1] = gg | (gp & gc[gi]);
    end
    for (int gi = 0; gi < GROUPS; gi++) begin
      c = gc[gi];
      for (int k = 0; k < 4; k++) begin
        s[4*gi+k] = p[4*gi+k] ^ c;
        c = g[4*gi+k] | (p[4*gi+k] & c);
      end
    end
    return {gc[GROUPS], s};
  endfunction

  assign {cout, sum} = cla_add(a, b, cin);

endmodule

// File: rtl/mult_dp.sv
// Shift-and-add multiplier datapath: multiplicand, accumulator and partial
// low word, advanced one multiplier bit per step.
module mult_dp
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] plo;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum_lo;
  logic             sum_co;
  logic [WIDTH:0]   sum;

  assign addend = plo[0] ? mcand : '0;

  cla_level2_32bit #(.WIDTH(WIDTH)) u_add (
    .a    (acc[WIDTH-1:0]),
    .b    (addend),
    .cin  (acc[WIDTH]),
    .sum  (sum_lo),
    .cout (sum_co)
  );

  assign sum = {sum_co, sum_lo};

  // {acc, plo} <= {1'b0, sum, plo} >> 1: the carry lands in the top of the
  // shifted accumulator, so acc[WIDTH] is always clear after a step.
  assign hi_next = sum[WIDTH:1];
  assign lo_next = {sum[0], plo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
      acc   <= '0;
      plo   <= '0;
    end else if (load) begin
      mcand <= a;
      acc   <= '0;
      plo   <= b;
    end else if (step) begin
      acc   <= {1'b0, hi_next};
      plo   <= lo_next;
    end
  end

endmodule

// File: rtl/mult_unit.sv
// Sequential unsigned multiplier controller: FSM, iteration counter and the
// HI/LO result registers around the shift-and-add datapath.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last result
// CALC  | one multiplier bit per cycle, WIDTH cycles
// DONE  | done pulse, new hi/lo visible, back to IDLE
module mult_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t      state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             load, step, finish;
  logic [WIDTH-1:0] hi_next, lo_next;

  mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .a       (a),
    .b       (b),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      if (load)
        cnt <= '0;
      else if (step)
        cnt <= cnt + 1'b1;
      // Capture the post-shift value of the final iteration.
      if (finish) begin
        hi <= hi_next;
        lo <= lo_next;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: the driver queues expected results with their
// due cycle, a monitor pops and checks them on every done pulse.
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t sb[$];

  mult_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request in the current cycle; the result is due 33 cycles later.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    a     = av;
    b     = bv;
    start = 1'b1;
    e.hi  = ehi;
    e.lo  = elo;
    e.due = cyc + 33;
    sb.push_back(e);
    step(1);
    start = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("done_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  // Stimulus
  initial begin
    int nbusy;
    int k;
    exp_t e;

    step(3);
    reset = 1'b0;
    step(5);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    step(1);

    // 3 x 5, with busy counted over the whole operation
    issue(32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    chk("busy_cycles", 64'(nbusy), 64'd33);
    step(2);

    // All ones: carry out of every add
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    step(40);

    // Back-to-back at the minimum interval (34 cycles)
    issue(32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    step(33);
    issue(32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);
    step(5);
    @(negedge clk);
    chk("hold_hi", 64'(hi), 64'h1);
    chk("hold_lo", 64'(lo), 64'h0);
    step(35);

    // start held high; operands change mid-CALC
    k     = cyc;
    a     = 32'h89AB_CDEF;
    b     = 32'h0000_0002;
    start = 1'b1;
    e.hi = 32'h0000_0001; e.lo = 32'h1357_9BDE; e.due = k + 33;
    sb.push_back(e);
    e.hi = 32'h0000_0000; e.lo = 32'h0000_0200; e.due = k + 67;
    sb.push_back(e);
    step(10);
    a = 32'h0000_0010;
    b = 32'h0000_0020;
    step(30);
    start = 1'b0;
    step(35);

    // Reset during CALC iteration 10: no done, hi/lo cleared
    a     = 32'hFFFF_0000;
    b     = 32'h0000_FFFF;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(9);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    step(40);

    // reset and start on the same edge: request dropped
    reset = 1'b1;
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd9;
    step(1);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 64'(busy), 64'd0);
    step(1);
    @(negedge clk);
    chk("rst_start_busy2", 64'(busy), 64'd0);
    step(1);

    issue(32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A);

    for (int i = 0; i < 200 && sb.size() != 0; i++) step(1);
    step(5);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
